// File: rtl/pipeline_sequencer_pkg.sv
// pipeline_sequencer_pkg
//   Shared definitions for the MIPS pipeline sequencer slice: FSM state
//   encoding, default widths, and the HALT opcode used by the decoder that
//   produces i_halt_detect.
//   Optional feature macro: PIPELINE_SEQ_CYCLE_COUNTER_EN (see pipeline_sequencer.sv).
package pipeline_sequencer_pkg;

   localparam int unsigned DRAIN_CYCLES_DEF = 4;
   localparam int unsigned NB_REG_DEF       = 5;
   localparam int unsigned NB_CNT_DEF       = 32;

   localparam logic [5:0]  HALT_OPCODE      = 6'b111111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Decoder helper: true when the fetched opcode is HALT.
   function automatic logic is_halt(input logic [5:0] i_opcode);
      return (i_opcode == HALT_OPCODE);
   endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if
//   Groups the sequencer's control inputs (start/step/hazard information) and
//   its control outputs (stage write/flush enables, status) into one bundle.
//   Signal prefixes are from the sequencer's point of view.
//   Modports:
//     master - environment side: drives i_*, observes o_*.
//     slave  - sequencer side:   reads i_*, drives o_*.
//   Related macro: PIPELINE_SEQ_CYCLE_COUNTER_EN (controls o_cycle_count).
interface pipeline_sequencer_if
   import pipeline_sequencer_pkg::*;
#(
   parameter int unsigned NB_REG = NB_REG_DEF,
   parameter int unsigned NB_CNT = NB_CNT_DEF
);

   logic              i_start;
   logic              i_mode_step;
   logic              i_step;
   logic              i_halt_detect;
   logic              i_branch_taken;
   logic              i_idex_memread;
   logic [NB_REG-1:0] i_idex_rt;
   logic [NB_REG-1:0] i_ifid_rs;
   logic [NB_REG-1:0] i_ifid_rt;

   logic              o_pipe_enable;
   logic              o_pc_write;
   logic              o_ifid_write;
   logic              o_ifid_flush;
   logic              o_idex_bubble;
   logic              o_done;
   logic [2:0]        o_state;
   logic [NB_CNT-1:0] o_cycle_count;

   modport master (
      output i_start, i_mode_step, i_step, i_halt_detect, i_branch_taken,
             i_idex_memread, i_idex_rt, i_ifid_rs, i_ifid_rt,
      input  o_pipe_enable, o_pc_write, o_ifid_write, o_ifid_flush,
             o_idex_bubble, o_done, o_state, o_cycle_count
   );

   modport slave (
      input  i_start, i_mode_step, i_step, i_halt_detect, i_branch_taken,
             i_idex_memread, i_idex_rt, i_ifid_rs, i_ifid_rt,
      output o_pipe_enable, o_pc_write, o_ifid_write, o_ifid_flush,
             o_idex_bubble, o_done, o_state, o_cycle_count
   );

endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// hazard_detect
//   Combinational load-use hazard comparator. Flags a stall when the
//   instruction in ID/EX is a load whose destination (non-zero) is a source
//   of the instruction currently in IF/ID.
//   Ports:
//     i_idex_memread - ID/EX instruction is a load
//     i_idex_rt      - load destination register
//     i_ifid_rs/rt   - source registers of the IF/ID instruction
//     o_stall        - load-use hazard present
module hazard_detect
   import pipeline_sequencer_pkg::*;
#(
   parameter int unsigned NB_REG = NB_REG_DEF
) (
   input  logic              i_idex_memread,
   input  logic [NB_REG-1:0] i_idex_rt,
   input  logic [NB_REG-1:0] i_ifid_rs,
   input  logic [NB_REG-1:0] i_ifid_rt,
   output logic              o_stall
);

   logic w_rt_nonzero;
   logic w_src_match;

   // $zero is never a real dependency
   assign w_rt_nonzero = (i_idex_rt != '0);
   assign w_src_match  = (i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt);
   assign o_stall      = i_idex_memread && w_rt_nonzero && w_src_match;

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
//   Sequences the 5-stage MIPS pipeline. Issues per-cycle advance enables in
//   continuous or single-step mode, inserts load-use bubbles, flushes IF/ID on
//   taken branches, and drains the pipeline for DRAIN_CYCLES advances after a
//   HALT reaches IF/ID, then reports done.
//   Ports:
//     i_clk   - clock, rising edge
//     i_reset - asynchronous active-high reset
//     bus     - pipeline_sequencer_if.slave: start/step/hazard inputs,
//               PC/IF/ID/ID/EX control outputs, done, state, cycle count
//   Control outputs are Mealy (combinational from state and inputs).
//   Macro PIPELINE_SEQ_CYCLE_COUNTER_EN: when defined, an NB_CNT-bit counter
//   of advanced cycles drives o_cycle_count; otherwise o_cycle_count is 0.
module pipeline_sequencer
   import pipeline_sequencer_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int unsigned NB_REG       = NB_REG_DEF,
   parameter int unsigned NB_CNT       = NB_CNT_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   pipeline_sequencer_if.slave  bus
);

   localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

   state_t          r_state;
   state_t          w_next_state;
   logic            r_step_mode;
   logic [DW-1:0]   r_drain_cnt;

   logic            w_stall;
   logic            w_adv;
   logic            w_pc_write;
   logic            w_ifid_write;
   logic            w_ifid_flush;
   logic            w_idex_bubble;
   logic            w_drain_load;
   logic            w_start;

   hazard_detect #(
      .NB_REG (NB_REG)
   ) u_hazard_detect (
      .i_idex_memread (bus.i_idex_memread),
      .i_idex_rt      (bus.i_idex_rt),
      .i_ifid_rs      (bus.i_ifid_rs),
      .i_ifid_rt      (bus.i_ifid_rt),
      .o_stall        (w_stall)
   );

   assign w_start = (r_state == ST_IDLE) && bus.i_start;

   // Next-state and Mealy control outputs
   always_comb begin
      w_next_state  = r_state;
      w_adv         = 1'b0;
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      w_drain_load  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.i_start)
               w_next_state = bus.i_mode_step ? ST_STEP : ST_RUN;
         end

         ST_RUN, ST_STEP: begin
            w_adv = (r_state == ST_RUN) || bus.i_step;
            if (w_adv) begin
               if (bus.i_branch_taken) begin
                  // Wrong-path instruction: stall and halt are discarded
                  w_ifid_flush = 1'b1;
                  w_pc_write   = 1'b1;
               end else if (w_stall) begin
                  // HALT (if any) is held in IF/ID and re-seen next cycle
                  w_idex_bubble = 1'b1;
               end else if (bus.i_halt_detect) begin
                  w_ifid_flush = 1'b1;
                  w_drain_load = 1'b1;
                  w_next_state = ST_DRAIN;
               end else begin
                  w_pc_write   = 1'b1;
                  w_ifid_write = 1'b1;
               end
            end
         end

         ST_DRAIN: begin
            // Fetch is frozen while draining; hazard inputs do not apply
            w_adv = r_step_mode ? bus.i_step : 1'b1;
            if (w_adv) begin
               w_ifid_flush = 1'b1;
               if (r_drain_cnt == '0)
                  w_next_state = ST_DONE;
            end
         end

         ST_DONE: begin
            w_next_state = ST_DONE;
         end

         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_step_mode <= 1'b0;
         r_drain_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_start)
            r_step_mode <= bus.i_mode_step;
         if (w_drain_load)
            r_drain_cnt <= DRAIN_INIT;
         else if ((r_state == ST_DRAIN) && w_adv && (r_drain_cnt != '0))
            r_drain_cnt <= r_drain_cnt - DW'(1);
      end
   end

`ifdef PIPELINE_SEQ_CYCLE_COUNTER_EN
   logic [NB_CNT-1:0] r_cycle_count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_cycle_count <= '0;
      else if (w_start)
         r_cycle_count <= '0;
      else if (w_adv)
         r_cycle_count <= r_cycle_count + NB_CNT'(1);
   end

   assign bus.o_cycle_count = r_cycle_count;
`else
   assign bus.o_cycle_count = {NB_CNT{1'b0}};
`endif

   assign bus.o_pipe_enable = w_adv;
   assign bus.o_pc_write    = w_pc_write;
   assign bus.o_ifid_write  = w_ifid_write;
   assign bus.o_ifid_flush  = w_ifid_flush;
   assign bus.o_idex_bubble = w_idex_bubble;
   assign bus.o_done        = (r_state == ST_DONE);
   assign bus.o_state       = r_state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
//   Directed self-checking bench for pipeline_sequencer: continuous run to
//   HALT/done, load-use stalls, branch priority, step mode, reset mid-drain.
//   Expected cycle counts follow PIPELINE_SEQ_CYCLE_COUNTER_EN.
module tb_pipeline_sequencer;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   pipeline_sequencer_if #(.NB_REG(5), .NB_CNT(32)) bus ();

   pipeline_sequencer #(
      .DRAIN_CYCLES (4),
      .NB_REG       (5),
      .NB_CNT       (32)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] ecnt(input int unsigned v);
`ifdef PIPELINE_SEQ_CYCLE_COUNTER_EN
      return v;
`else
      return (v == 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      bus.i_start        = 1'b0;
      bus.i_mode_step    = 1'b0;
      bus.i_step         = 1'b0;
      bus.i_halt_detect  = 1'b0;
      bus.i_branch_taken = 1'b0;
      bus.i_idex_memread = 1'b0;
      bus.i_idex_rt      = '0;
      bus.i_ifid_rs      = '0;
      bus.i_ifid_rt      = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clr_in();
      cyc();
      cyc();
      rst = 1'b0;
      #1;
   endtask

   task automatic start(input logic mode);
      bus.i_start     = 1'b1;
      bus.i_mode_step = mode;
      cyc();
      bus.i_start     = 1'b0;
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      clr_in();

      // ---------------- reset state
      #3;
      chk("rst_state", 32'(bus.o_state), 32'd0);
      chk("rst_pipe_en", 32'(bus.o_pipe_enable), 32'd0);
      chk("rst_done", 32'(bus.o_done), 32'd0);
      chk("rst_cnt", bus.o_cycle_count, 32'd0);
      do_reset();
      chk("idle_pc_write", 32'(bus.o_pc_write), 32'd0);

      // ---------------- continuous run, HALT at cycle 10
      start(1'b0);
      chk("run_state", 32'(bus.o_state), 32'd1);
      for (int i = 1; i <= 9; i++) begin
         chk("run_pc_write", 32'(bus.o_pc_write), 32'd1);
         chk("run_ifid_write", 32'(bus.o_ifid_write), 32'd1);
         cyc();
      end
      chk("run_cnt9", bus.o_cycle_count, ecnt(9));
      bus.i_halt_detect = 1'b1;
      #1;
      chk("halt_pc_write", 32'(bus.o_pc_write), 32'd0);
      chk("halt_flush", 32'(bus.o_ifid_flush), 32'd1);
      chk("halt_pipe_en", 32'(bus.o_pipe_enable), 32'd1);
      cyc();
      bus.i_halt_detect = 1'b0;
      chk("drain_state", 32'(bus.o_state), 32'd3);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_done", 32'(bus.o_done), 32'd0);
         chk("drain_pc_write", 32'(bus.o_pc_write), 32'd0);
         chk("drain_flush", 32'(bus.o_ifid_flush), 32'd1);
         cyc();
      end
      chk("done_flag", 32'(bus.o_done), 32'd1);
      chk("done_state", 32'(bus.o_state), 32'd4);
      chk("done_cnt", bus.o_cycle_count, ecnt(14));
      chk("done_pipe_en", 32'(bus.o_pipe_enable), 32'd0);
      // DONE is sticky: start is ignored
      bus.i_start = 1'b1;
      cyc();
      cyc();
      bus.i_start = 1'b0;
      #1;
      chk("done_sticky", 32'(bus.o_state), 32'd4);
      chk("done_sticky_cnt", bus.o_cycle_count, ecnt(14));

      // ---------------- load-use stalls
      do_reset();
      start(1'b0);
      bus.i_idex_memread = 1'b1;
      bus.i_idex_rt      = 5'd5;
      bus.i_ifid_rs      = 5'd5;
      bus.i_ifid_rt      = 5'd9;
      #1;
      chk("lu_pc_write", 32'(bus.o_pc_write), 32'd0);
      chk("lu_ifid_write", 32'(bus.o_ifid_write), 32'd0);
      chk("lu_bubble", 32'(bus.o_idex_bubble), 32'd1);
      chk("lu_pipe_en", 32'(bus.o_pipe_enable), 32'd1);
      cyc();
      bus.i_idex_memread = 1'b0;
      #1;
      chk("lu_after_pc", 32'(bus.o_pc_write), 32'd1);
      chk("lu_after_bubble", 32'(bus.o_idex_bubble), 32'd0);
      cyc();
      chk("lu_cnt", bus.o_cycle_count, ecnt(2));
      // rt = 0 never stalls
      bus.i_idex_memread = 1'b1;
      bus.i_idex_rt      = 5'd0;
      bus.i_ifid_rs      = 5'd0;
      bus.i_ifid_rt      = 5'd0;
      #1;
      chk("lu_rt0_bubble", 32'(bus.o_idex_bubble), 32'd0);
      chk("lu_rt0_pc", 32'(bus.o_pc_write), 32'd1);
      // match on rt source
      bus.i_idex_rt = 5'd7;
      bus.i_ifid_rs = 5'd3;
      bus.i_ifid_rt = 5'd7;
      #1;
      chk("lu_rt_bubble", 32'(bus.o_idex_bubble), 32'd1);
      // no source match
      bus.i_ifid_rt = 5'd6;
      #1;
      chk("lu_nomatch", 32'(bus.o_idex_bubble), 32'd0);
      // memread low
      bus.i_ifid_rt      = 5'd7;
      bus.i_idex_memread = 1'b0;
      #1;
      chk("lu_nomem", 32'(bus.o_idex_bubble), 32'd0);
      cyc();

      // ---------------- branch + stall + halt together
      bus.i_branch_taken = 1'b1;
      bus.i_idex_memread = 1'b1;
      bus.i_idex_rt      = 5'd5;
      bus.i_ifid_rs      = 5'd5;
      bus.i_halt_detect  = 1'b1;
      #1;
      chk("br_flush", 32'(bus.o_ifid_flush), 32'd1);
      chk("br_pc_write", 32'(bus.o_pc_write), 32'd1);
      chk("br_bubble", 32'(bus.o_idex_bubble), 32'd0);
      cyc();
      chk("br_state", 32'(bus.o_state), 32'd1);

      // stall + halt: halt held off this cycle
      bus.i_branch_taken = 1'b0;
      #1;
      chk("st_halt_bubble", 32'(bus.o_idex_bubble), 32'd1);
      chk("st_halt_flush", 32'(bus.o_ifid_flush), 32'd0);
      cyc();
      chk("st_halt_state", 32'(bus.o_state), 32'd1);
      bus.i_idex_memread = 1'b0;
      #1;
      chk("halt2_flush", 32'(bus.o_ifid_flush), 32'd1);
      cyc();
      bus.i_halt_detect = 1'b0;
      chk("halt2_state", 32'(bus.o_state), 32'd3);
      cyc();
      // now in DRAIN with counter 2: reset asynchronously mid-cycle
      chk("mid_drain_state", 32'(bus.o_state), 32'd3);
      chk("mid_drain_pe", 32'(bus.o_pipe_enable), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_state", 32'(bus.o_state), 32'd0);
      chk("arst_pe", 32'(bus.o_pipe_enable), 32'd0);
      chk("arst_flush", 32'(bus.o_ifid_flush), 32'd0);
      chk("arst_done", 32'(bus.o_done), 32'd0);
      chk("arst_cnt", bus.o_cycle_count, 32'd0);
      cyc();
      rst = 1'b0;
      #1;
      start(1'b0);
      chk("restart_cnt", bus.o_cycle_count, 32'd0);
      cyc();
      cyc();
      chk("restart_cnt2", bus.o_cycle_count, ecnt(2));

      // ---------------- step mode: 3 pulses over 20 cycles
      do_reset();
      start(1'b1);
      bus.i_mode_step = 1'b0;  // flag latched at start must hold
      chk("step_state", 32'(bus.o_state), 32'd2);
      for (int c = 0; c < 20; c++) begin
         bus.i_step = (c == 3 || c == 8 || c == 15);
         #1;
         chk("step_pe", 32'(bus.o_pipe_enable), 32'(bus.i_step));
         cyc();
      end
      bus.i_step = 1'b0;
      chk("step_cnt", bus.o_cycle_count, ecnt(3));
      // halt without step is not acted on
      bus.i_halt_detect = 1'b1;
      #1;
      chk("step_halt_noadv", 32'(bus.o_ifid_flush), 32'd0);
      cyc();
      chk("step_halt_state", 32'(bus.o_state), 32'd2);
      bus.i_step = 1'b1;
      cyc();
      bus.i_step        = 1'b0;
      bus.i_halt_detect = 1'b0;
      chk("step_drain", 32'(bus.o_state), 32'd3);
      cyc();
      cyc();
      chk("step_drain_hold", 32'(bus.o_state), 32'd3);
      for (int i = 0; i < 4; i++) begin
         chk("step_drain_nd", 32'(bus.o_done), 32'd0);
         bus.i_step = 1'b1;
         cyc();
         bus.i_step = 1'b0;
         cyc();
      end
      chk("step_done", 32'(bus.o_done), 32'd1);
      chk("step_done_cnt", bus.o_cycle_count, ecnt(8));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Sequences the 5-stage MIPS pipeline: issues per-cycle stage enables in continuous-run or single-step mode, inserts load-use stalls, flushes IF/ID on taken branches, and drains the pipeline after a HALT is fetched. It sits beside the main and ALU control units. It drives the PC, IF/ID and ID/EX write/flush controls, and reports completion and executed-cycle count to the debug interface.

## Interface
- `DRAIN_CYCLES`, 4: advanced cycles after HALT is detected before `o_done`.
- `NB_REG`, 5: register-index width.
- `NB_CNT`, 32: cycle-counter width.
- `i_clk` in 1: clock, rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_start` in 1: one-cycle pulse; leaves IDLE.
- `i_mode_step` in 1: sampled on start; 1 = step mode, 0 = continuous.
- `i_step` in 1: in step mode, advance the pipeline this cycle.
- `i_halt_detect` in 1: instruction in IF/ID is HALT.
- `i_branch_taken` in 1: branch in ID/EX resolved taken.
- `i_idex_memread` in 1: instruction in ID/EX is a load.
- `i_idex_rt` in NB_REG: load destination.
- `i_ifid_rs`, `i_ifid_rt` in NB_REG: sources of the instruction in IF/ID.
- `o_pipe_enable` out 1: all stage registers update this cycle.
- `o_pc_write` out 1: PC updates.
- `o_ifid_write` out 1: IF/ID updates.
- `o_ifid_flush` out 1: IF/ID loads a NOP.
- `o_idex_bubble` out 1: ID/EX loads a NOP.
- `o_done` out 1: program finished, pipeline drained.
- `o_state` out 3: current FSM state.
- `o_cycle_count` out NB_CNT: number of advanced cycles.

## Operation
- States: IDLE, RUN, STEP, DRAIN, DONE.
- IDLE → RUN when `i_start` and not `i_mode_step`.
- IDLE → STEP when `i_start` and `i_mode_step`.
- The step flag is latched at start and held for the rest of the run.
- "adv" (cycle advances):
  - RUN: 1.
  - STEP: `i_step`.
  - DRAIN: 1 when continuous, `i_step` when in step mode.
  - IDLE and DONE: 0.
- `o_pipe_enable` = adv.
- When adv=0, all other control outputs are 0.
- Priority when adv=1, highest first:
  1. `i_branch_taken`: `o_ifid_flush`=1, `o_pc_write`=1; the stall and `i_halt_detect` are ignored (wrong path).
  2. Load-use: `i_idex_memread` and `i_idex_rt`≠0 and (`i_idex_rt`==`i_ifid_rs` or `i_idex_rt`==`i_ifid_rt`). Response: `o_pc_write`=0, `o_ifid_write`=0, `o_idex_bubble`=1; the halt is ignored this cycle and is re-seen next cycle.
  3. `i_halt_detect` in RUN or STEP: `o_pc_write`=0, `o_ifid_flush`=1; next state is DRAIN with the drain counter = DRAIN_CYCLES−1.
  4. Otherwise: `o_pc_write`=1, `o_ifid_write`=1.
- DRAIN:
  - `o_pc_write`=0 and `o_ifid_flush`=1 on every adv.
  - The counter decrements on adv.
  - On adv with counter 0, go to DONE.
- DONE: `o_done`=1, all enables 0. DONE is sticky; only `i_reset` leaves it.
- `i_start` outside IDLE is ignored.
- `i_step` outside step mode is ignored.
- Cycle counter: cleared on IDLE→RUN/STEP; increments on every adv; wraps modulo 2^NB_CNT.

## Timing
- Control outputs are Mealy: combinational from state and inputs, and valid in the same cycle as the hazard or step input.
- State, drain counter and cycle counter are registered.
- `o_done` rises the cycle after the final drain adv.
- Total HALT-to-done latency is DRAIN_CYCLES advances.
- Reset values:
  - state = IDLE.
  - all outputs 0.
  - `o_cycle_count`=0.
- Asserting `i_reset` in any state, including mid-drain or mid-stall, drops every output to 0 immediately (asynchronously) and returns the FSM to IDLE.

## Configuration
- `PIPELINE_SEQ_CYCLE_COUNTER_EN`
  - Defined: the NB_CNT-bit cycle counter is built and drives `o_cycle_count`.
  - Undefined: no counter register; `o_cycle_count` is tied to 0; all other behaviour is unchanged.

## Structure
- Shared package holds:
  - State encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4.
  - HALT opcode constant `6'b111111`, used by the decoder that generates `i_halt_detect`.
  - Default widths NB_REG and NB_CNT.
- One sub-module, `hazard_detect`: combinational load-use comparator producing the stall flag from the `i_idex_*` and `i_ifid_*` inputs.

## Test plan
- Continuous, no hazards: start with mode=0, HALT asserted at cycle 10.
  - Required: `o_pc_write`=0 at cycle 10.
  - Required: `o_done`=1 after 4 more advances; `o_cycle_count`=14.
- Load-use, `i_idex_memread`=1, rt=5:
  - With `i_ifid_rs`=5: exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1.
  - With rt=0: no stall.
- Branch + stall + halt simultaneously:
  - Required: flush=1, pc_write=1, bubble=0.
  - Required: state stays RUN.
- Step mode, `i_step` pulsed 3 times over 20 cycles: `o_pipe_enable` high exactly 3 cycles; `o_cycle_count`=3.
- Reset asserted mid-DRAIN (counter=2): all outputs 0 before the next clock edge; state=IDLE; `i_start` restarts with the counter cleared.
- Macro undefined, repeat the continuous scenario: `o_cycle_count` stays 0 throughout; `o_done` timing is identical.
